// File: rtl/posit_result_arbiter.sv
// rtl/posit_result_arbiter.sv - round-robin collector of posit slice results onto one valid/ready port
package posit_pkg;
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;
endpackage

module posit_result_arbiter #(
  parameter int unsigned NumLanes = 3,
  parameter int unsigned Width    = 32,
  parameter type         TagType  = logic,
  localparam int unsigned LaneIdxWidth = NumLanes > 1 ? $clog2(NumLanes) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumLanes-1:0][Width-1:0]      slice_result_i,
  input  posit_pkg::status_t [NumLanes-1:0]   slice_status_i,
  input  logic [NumLanes-1:0]                 slice_ext_bit_i,
  input  TagType [NumLanes-1:0]               slice_tag_i,
  input  logic [NumLanes-1:0]                 slice_valid_i,
  output logic [NumLanes-1:0]                 slice_ready_o,
  input  logic [NumLanes-1:0]                 slice_busy_i,
  input  logic                                flush_i,
  output logic [Width-1:0]                    result_o,
  output posit_pkg::status_t                  status_o,
  output logic                                extension_bit_o,
  output TagType                              tag_o,
  output logic [LaneIdxWidth-1:0]             lane_o,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic                                busy_o
);

  logic [LaneIdxWidth-1:0] prio_q;
  logic [LaneIdxWidth-1:0] winner;
  logic [LaneIdxWidth-1:0] idx;
  logic [LaneIdxWidth-1:0] next_prio;
  logic                    found;
  logic                    can_load;
  logic                    transfer;

  // Deliberately independent of slice_valid_i so slices may wait on ready.
  assign can_load = !out_valid_o | out_ready_i;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = prio_q;
    for (int i = 0; i < NumLanes; i++) begin
      if (!found && slice_valid_i[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
      idx = (idx == LaneIdxWidth'(NumLanes - 1)) ? '0 : idx + 1'b1;
    end
  end

  assign transfer  = found & can_load & !flush_i;
  assign next_prio = (winner == LaneIdxWidth'(NumLanes - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    slice_ready_o = '0;
    if (transfer) begin
      slice_ready_o[winner] = 1'b1;
    end
  end

  assign busy_o = out_valid_o | (|slice_busy_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o     <= 1'b0;
      result_o        <= '0;
      status_o        <= '0;
      extension_bit_o <= 1'b0;
      tag_o           <= '0;
      lane_o          <= '0;
      prio_q          <= '0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (transfer) begin
      out_valid_o     <= 1'b1;
      result_o        <= slice_result_i[winner];
      status_o        <= slice_status_i[winner];
      extension_bit_o <= slice_ext_bit_i[winner];
      tag_o           <= slice_tag_i[winner];
      lane_o          <= winner;
      prio_q          <= next_prio;
    end else if (out_ready_i) begin
      // Drain without refill: data registers keep their last values.
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_posit_result_arbiter.sv
// tb/tb_posit_result_arbiter.sv - directed self-checking bench for posit_result_arbiter
module tb_posit_result_arbiter;

  logic                     clk;
  logic                     rst_n;
  logic [2:0][31:0]         slice_result;
  posit_pkg::status_t [2:0] slice_status;
  logic [2:0]               slice_ext_bit;
  logic [2:0][3:0]          slice_tag;
  logic [2:0]               slice_valid;
  logic [2:0]               slice_ready;
  logic [2:0]               slice_busy;
  logic                     flush;
  logic [31:0]              result;
  posit_pkg::status_t       status;
  logic                     extension_bit;
  logic [3:0]               tag;
  logic [1:0]               lane;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;

  int errors = 0;
  int checks = 0;
  int exp_l;

  posit_result_arbiter #(
    .NumLanes(3),
    .Width(32),
    .TagType(logic [3:0])
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .slice_result_i(slice_result),
    .slice_status_i(slice_status),
    .slice_ext_bit_i(slice_ext_bit),
    .slice_tag_i(slice_tag),
    .slice_valid_i(slice_valid),
    .slice_ready_o(slice_ready),
    .slice_busy_i(slice_busy),
    .flush_i(flush),
    .result_o(result),
    .status_o(status),
    .extension_bit_o(extension_bit),
    .tag_o(tag),
    .lane_o(lane),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    slice_result  = '0;
    slice_status  = '0;
    slice_ext_bit = '0;
    slice_tag     = '0;
    slice_valid   = '0;
    slice_busy    = '0;
    flush         = 1'b0;
    out_ready     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    // Reset state
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_status", status, 5'b0);
    chk("rst_ext", extension_bit, 1'b0);
    chk("rst_tag", tag, 4'h0);
    chk("rst_lane", lane, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", slice_ready, 3'b000);

    // Single lane-1 result, one-cycle latency
    slice_valid[1]   = 1'b1;
    slice_result[1]  = 32'h4000_0000;
    slice_tag[1]     = 4'd5;
    slice_ext_bit[1] = 1'b1;
    #1;
    chk("single_ready", slice_ready, 3'b010);
    tick();
    slice_valid = '0;
    chk("single_valid", out_valid, 1'b1);
    chk("single_result", result, 32'h4000_0000);
    chk("single_tag", tag, 4'd5);
    chk("single_ext", extension_bit, 1'b1);
    chk("single_lane", lane, 2'd1);
    chk("single_busy", busy, 1'b1);

    // All lanes valid, consumer always ready: pointer now sits at lane 2
    out_ready = 1'b1;
    for (int l = 0; l < 3; l++) begin
      slice_result[l]  = 32'hA0 + 32'(l);
      slice_tag[l]     = 4'(l + 8);
      slice_status[l]  = 5'(l + 1);
      slice_ext_bit[l] = 1'b0;
    end
    slice_valid = 3'b111;
    exp_l = 2;
    for (int n = 0; n < 6; n++) begin
      #1;
      chk("rr_ready", slice_ready, 64'(3'b001 << exp_l));
      tick();
      chk("rr_valid", out_valid, 1'b1);
      chk("rr_lane", lane, 64'(exp_l));
      chk("rr_result", result, 64'(32'hA0 + exp_l));
      chk("rr_tag", tag, 64'(exp_l + 8));
      exp_l = (exp_l == 2) ? 0 : exp_l + 1;
    end

    // Stall with lane 2 pending: lane 1 result held, no grants
    out_ready       = 1'b0;
    slice_valid     = 3'b100;
    slice_result[2] = 32'hC2;
    slice_status[2] = 5'b00001;
    for (int n = 0; n < 4; n++) begin
      #1;
      chk("stall_ready", slice_ready, 3'b000);
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_result", result, 32'hA1);
      chk("stall_lane", lane, 2'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_ready", slice_ready, 3'b100);
    tick();
    chk("unstall_result", result, 32'hC2);
    chk("unstall_status", status, 5'b00001);
    chk("unstall_lane", lane, 2'd2);

    // Wrap: get pointer to 2 via lane 1, then lane 0 alone wins
    slice_valid = 3'b010;
    tick();
    chk("pre_wrap_lane", lane, 2'd1);
    chk("pre_wrap_prio", dut.prio_q, 2'd2);
    slice_valid = 3'b001;
    #1;
    chk("wrap_ready", slice_ready, 3'b001);
    tick();
    chk("wrap_lane", lane, 2'd0);
    chk("wrap_prio", dut.prio_q, 2'd1);

    // Flush with lane 1 requesting and consumer ready
    slice_valid     = 3'b010;
    slice_result[1] = 32'hF1;
    flush           = 1'b1;
    #1;
    chk("flush_ready", slice_ready, 3'b000);
    tick();
    flush = 1'b0;
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_lane", lane, 2'd0);
    chk("flush_result", result, 32'hA0);
    chk("flush_prio", dut.prio_q, 2'd1);
    #1;
    chk("post_flush_ready", slice_ready, 3'b010);
    tick();
    chk("post_flush_valid", out_valid, 1'b1);
    chk("post_flush_result", result, 32'hF1);
    chk("post_flush_lane", lane, 2'd1);

    // Drain without refill
    slice_valid = 3'b000;
    tick();
    chk("drain_valid", out_valid, 1'b0);
    chk("drain_result", result, 32'hF1);
    slice_busy = 3'b100;
    #1;
    chk("busy_slice", busy, 1'b1);

    // Async reset mid-cycle with a result held and pointer nonzero
    slice_valid = 3'b001;
    tick();
    slice_valid = 3'b000;
    out_ready   = 1'b0;
    chk("pre_rst_valid", out_valid, 1'b1);
    chk("pre_rst_prio", dut.prio_q, 2'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_prio", dut.prio_q, 2'd0);
    chk("arst_result", result, 32'h0);
    chk("arst_busy_slice", busy, 1'b1);
    slice_busy = 3'b000;
    #1;
    chk("arst_busy_idle", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("after_rst_valid", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/posit_result_arbiter.md
# posit_result_arbiter

Collects results from the posit opgroup slices (ADDMUL, DIVSQRT, NONCOMP) and returns them to the core over one valid/ready result port. It is the consumer end of each slice's output handshake (`out_valid_o`/`out_ready_i`). Lanes are arbitrated round-robin into a single output register. Result, status, extension bit and tag pass through unchanged, and the winning lane index is reported alongside them.

## Interface
Parameters:
- `NumLanes`, 3: number of slice output ports; lane 0 = ADDMUL, 1 = DIVSQRT, 2 = NONCOMP; legal range 1..8
- `Width`, 32: result width in bits
- `TagType`, logic: operation tag type, passed through opaquely
- `LaneIdxWidth`, localparam: `NumLanes > 1 ? $clog2(NumLanes) : 1`

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset; one clock, asynchronous, active-low
- `slice_result_i`  in  [NumLanes][Width]  per-lane result
- `slice_status_i`  in  [NumLanes] posit_pkg::status_t  per-lane status flags
- `slice_ext_bit_i`  in  [NumLanes]  per-lane extension bit
- `slice_tag_i`  in  [NumLanes] TagType  per-lane tag
- `slice_valid_i`  in  [NumLanes]  per-lane result valid
- `slice_ready_o`  out  [NumLanes]  per-lane ready; one-hot or zero
- `slice_busy_i`  in  [NumLanes]  per-lane busy (data in flight)
- `flush_i`  in  1  synchronous flush
- `result_o`  out  Width  registered result
- `status_o`  out  posit_pkg::status_t  registered status
- `extension_bit_o`  out  1  registered extension bit
- `tag_o`  out  TagType  registered tag
- `lane_o`  out  LaneIdxWidth  index of the lane that produced the held result
- `out_valid_o`  out  1  output register holds a result
- `out_ready_i`  in  1  consumer accepts the held result
- `busy_o`  out  1  result held here or data in flight in any slice

## Operation
Output register:
- Holds one result.
- `can_load = !out_valid_o | out_ready_i`.
- `can_load` and `flush_i` have no combinational dependence on any `slice_valid_i`.

Arbitration:
- Round-robin pointer `prio_q`, range 0..NumLanes-1.
- Requesting lanes are searched in order `prio_q, prio_q+1, …`, wrapping modulo NumLanes.
- The first requesting lane found wins.
- `slice_ready_o[w] = can_load & !flush_i` for the winner `w`; all other bits are 0.
- No request, or `can_load = 0`: all `slice_ready_o` are 0.

Transfer (winner `w` with `slice_valid_i[w] & slice_ready_o[w]`):
- On the next edge, load `result_o`, `status_o`, `extension_bit_o`, `tag_o` from lane `w`.
- Set `lane_o = w`, `out_valid_o = 1`.
- Set `prio_q = (w+1) mod NumLanes`. Wrap: from NumLanes-1 the pointer goes to 0.

Drain without refill:
- `out_valid_o & out_ready_i` with no transfer: `out_valid_o` → 0.
- Data outputs keep their last values.

Flush:
- `flush_i = 1`: `out_valid_o` → 0 on the next edge; no lane is granted that cycle.
- Data registers and `prio_q` are unchanged.

Busy: `busy_o = out_valid_o | (|slice_busy_i)`, combinational.

Lane with `slice_valid_i` low: its data inputs are ignored.

Reset (asynchronous, while `rst_ni = 0`):
- `out_valid_o = 0`, `result_o = '0`, `status_o = '0`, `extension_bit_o = 0`, `tag_o = '0`, `lane_o = 0`, `prio_q = 0`.
- Reset mid-transfer: the held result is dropped. Slices are reset by the same `rst_ni`.

## Timing
- Latency: exactly 1 cycle from slice handshake to `out_valid_o`.
- Throughput: 1 result per cycle while `out_ready_i` is held high.
- Stall: while `out_valid_o & !out_ready_i`, all outputs are stable and all `slice_ready_o` are 0.
- Simultaneous drain and refill in one cycle: `out_valid_o` stays 1 and the new data appears on the next edge, with no bubble.
- `slice_ready_o` is combinational from `slice_valid_i`, `prio_q`, `out_valid_o`, `out_ready_i`, `flush_i`.
- Fairness: a lane holding `slice_valid_i` high waits at most NumLanes-1 grants to other lanes before it is granted.
- Flush in the same cycle as `out_ready_i = 1` and a pending request: no grant; `out_valid_o` is 0 on the next cycle.

## Test plan
- Reset release with all valids low → all outputs 0 and `busy_o = 0`. Then lane 1 valid for 1 cycle with result 0x4000_0000, tag 5 → next cycle `out_valid_o = 1`, `result_o = 0x4000_0000`, `tag_o = 5`, `lane_o = 1`.
- Lanes 0, 1, 2 valid continuously, `out_ready_i = 1` → grant order 0, 1, 2, 0, 1, 2; one result per cycle; `lane_o` sequence is 0, 1, 2, …
- `out_ready_i = 0` for 4 cycles with lane 2 valid and status 5'b00001 → outputs frozen and `slice_ready_o = 0` throughout. Raise `out_ready_i` → lane 2's result appears the following cycle.
- Lane 0 valid and `prio_q = 2` with lane 2 idle → lane 0 is granted (wrap). `prio_q` becomes 1.
- `flush_i` pulse while `out_valid_o = 1` and lane 1 is requesting → `out_valid_o = 0` next cycle, lane 1 is not granted during the flush cycle, and lane 1 is granted the cycle after.
- `rst_ni` asserted asynchronously mid-stream → `out_valid_o` and `prio_q` clear immediately, without waiting for a clock edge. `busy_o` follows `slice_busy_i` only.
